// File: rtl/clock_pkg.sv
// Shared types for the day-of-week alarm clock.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RING,
        SNOOZE
    } alarm_st_t;

endpackage

// File: rtl/ct_mod_tc.sv
// Mod-N up counter with synchronous reset, count enable and a combinational
// terminal-count flag that is high while the count sits at N-1.
module ct_mod_tc #(
    parameter int N = 10,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] ct_out_o,
    output logic         tc_o
);

    logic [W-1:0] ct_q;
    logic [W-1:0] ct_d;

    assign tc_o     = (ct_q == W'(N - 1));
    assign ct_out_o = ct_q;

    always_comb begin
        ct_d = ct_q;
        if (en_i) begin
            ct_d = tc_o ? '0 : ct_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ct_q <= '0;
        end else begin
            ct_q <= ct_d;
        end
    end

endmodule

// File: rtl/alarm_clock_dow.sv
// Time-of-day / day-of-week clock with a day-masked alarm that auto-stops
// after RING_SEC pulses and can be snoozed for SNOOZE_MIN minutes.
module alarm_clock_dow
    import clock_pkg::*;
#(
    parameter int NS         = 60,
    parameter int NM         = 60,
    parameter int NH         = 24,
    parameter int ND         = 7,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                  Pulse_i,
    input  logic                  Reset_i,
    input  logic                  Timeset_i,
    input  logic                  Alarmset_i,
    input  logic                  Minadv_i,
    input  logic                  Hrsadv_i,
    input  logic                  Dayadv_i,
    input  logic                  Alarmon_i,
    input  logic                  Snooze_i,
    input  logic [ND-1:0]         AlarmDays_i,
    output logic [$clog2(NS)-1:0] TSec_o,
    output logic [$clog2(NM)-1:0] TMin_o,
    output logic [$clog2(NH)-1:0] THrs_o,
    output logic [$clog2(ND)-1:0] TDay_o,
    output logic [$clog2(NM)-1:0] AMin_o,
    output logic [$clog2(NH)-1:0] AHrs_o,
    output logic                  Buzz_o,
    output logic                  Snoozing_o
);

    localparam int SNZ_LEN = SNOOZE_MIN * NS;
    localparam int RW      = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam int SW      = (SNZ_LEN > 1) ? $clog2(SNZ_LEN) : 1;

    logic secTc, minTc, hrsTc;
    logic unusedDayTc, unusedAMinTc, unusedAHrsTc;
    logic secEn, minEn, hrsEn, dayEn, aMinEn, aHrsEn;
    logic sc, mc, hc;
    logic match;

    alarm_st_t     state_q;
    logic [RW-1:0] ringCnt_q;
    logic [SW-1:0] snzCnt_q;

    // Carries ripple only from the free-running chain; manual advances never carry.
    assign secEn  = !Timeset_i;
    assign sc     = secTc && !Timeset_i;
    assign minEn  = sc || (Timeset_i && Minadv_i);
    assign mc     = sc && minTc;
    assign hrsEn  = mc || (Timeset_i && Hrsadv_i);
    assign hc     = mc && hrsTc;
    assign dayEn  = hc || (Timeset_i && Dayadv_i);
    assign aMinEn = Alarmset_i && Minadv_i && !Timeset_i;
    assign aHrsEn = Alarmset_i && Hrsadv_i && !Timeset_i;

    ct_mod_tc #(.N(NS)) uSec (
        .clk_i(Pulse_i), .rst_i(Reset_i), .en_i(secEn), .ct_out_o(TSec_o), .tc_o(secTc)
    );
    ct_mod_tc #(.N(NM)) uMin (
        .clk_i(Pulse_i), .rst_i(Reset_i), .en_i(minEn), .ct_out_o(TMin_o), .tc_o(minTc)
    );
    ct_mod_tc #(.N(NH)) uHrs (
        .clk_i(Pulse_i), .rst_i(Reset_i), .en_i(hrsEn), .ct_out_o(THrs_o), .tc_o(hrsTc)
    );
    ct_mod_tc #(.N(ND)) uDay (
        .clk_i(Pulse_i), .rst_i(Reset_i), .en_i(dayEn), .ct_out_o(TDay_o), .tc_o(unusedDayTc)
    );
    ct_mod_tc #(.N(NM)) uAMin (
        .clk_i(Pulse_i), .rst_i(Reset_i), .en_i(aMinEn), .ct_out_o(AMin_o), .tc_o(unusedAMinTc)
    );
    ct_mod_tc #(.N(NH)) uAHrs (
        .clk_i(Pulse_i), .rst_i(Reset_i), .en_i(aHrsEn), .ct_out_o(AHrs_o), .tc_o(unusedAHrsTc)
    );

    assign match = Alarmon_i && !Timeset_i && (TSec_o == '0) &&
                   (TMin_o == AMin_o) && (THrs_o == AHrs_o) && AlarmDays_i[TDay_o];

    // Disarming beats snooze, which beats the ring timeout; match only counts in IDLE.
    always_ff @(posedge Pulse_i) begin
        if (Reset_i) begin
            state_q   <= IDLE;
            ringCnt_q <= '0;
            snzCnt_q  <= '0;
        end else if (!Alarmon_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match) begin
                        state_q   <= RING;
                        ringCnt_q <= '0;
                    end
                end
                RING: begin
                    if (Snooze_i) begin
                        state_q  <= SNOOZE;
                        snzCnt_q <= SW'(SNZ_LEN - 1);
                    end else if (ringCnt_q == RW'(RING_SEC - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        ringCnt_q <= ringCnt_q + 1'b1;
                    end
                end
                SNOOZE: begin
                    if (snzCnt_q == '0) begin
                        state_q   <= RING;
                        ringCnt_q <= '0;
                    end else begin
                        snzCnt_q <= snzCnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Buzz_o     = (state_q == RING);
    assign Snoozing_o = (state_q == SNOOZE);

endmodule

// File: tb/tb_alarm_clock_dow.sv
// Directed bench for alarm_clock_dow with a shrunken time base
// (4 s/min, 3 min/h, 2 h/day, 2 days/week, 3 s ring, 1 min snooze).
module tb_alarm_clock_dow;

    localparam int NS         = 4;
    localparam int NM         = 3;
    localparam int NH         = 2;
    localparam int ND         = 2;
    localparam int RING_SEC   = 3;
    localparam int SNOOZE_MIN = 1;

    logic                  Pulse = 1'b0;
    logic                  Reset, Timeset, Alarmset, Minadv, Hrsadv, Dayadv;
    logic                  Alarmon, Snooze;
    logic [ND-1:0]         AlarmDays;
    logic [$clog2(NS)-1:0] TSec;
    logic [$clog2(NM)-1:0] TMin, AMin;
    logic [$clog2(NH)-1:0] THrs, AHrs;
    logic [$clog2(ND)-1:0] TDay;
    logic                  Buzz, Snoozing;

    int checks = 0;
    int errors = 0;
    int t      = 0;

    alarm_clock_dow #(
        .NS(NS), .NM(NM), .NH(NH), .ND(ND), .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN)
    ) dut (
        .Pulse_i(Pulse), .Reset_i(Reset), .Timeset_i(Timeset), .Alarmset_i(Alarmset),
        .Minadv_i(Minadv), .Hrsadv_i(Hrsadv), .Dayadv_i(Dayadv), .Alarmon_i(Alarmon),
        .Snooze_i(Snooze), .AlarmDays_i(AlarmDays),
        .TSec_o(TSec), .TMin_o(TMin), .THrs_o(THrs), .TDay_o(TDay),
        .AMin_o(AMin), .AHrs_o(AHrs), .Buzz_o(Buzz), .Snoozing_o(Snoozing)
    );

    always #5 Pulse = ~Pulse;

    // Advance n pulses; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge Pulse);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkTime(input int tt);
        checkOutput($sformatf("TSec@%0d", tt), 32'(TSec), tt % NS);
        checkOutput($sformatf("TMin@%0d", tt), 32'(TMin), (tt / NS) % NM);
        checkOutput($sformatf("THrs@%0d", tt), 32'(THrs), (tt / (NS * NM)) % NH);
        checkOutput($sformatf("TDay@%0d", tt), 32'(TDay), (tt / (NS * NM * NH)) % ND);
    endtask

    task automatic checkAlarm(input logic expBuzz, input logic expSnz);
        checkOutput($sformatf("Buzz@%0d", t), 32'(Buzz), 32'(expBuzz));
        checkOutput($sformatf("Snoozing@%0d", t), 32'(Snoozing), 32'(expSnz));
    endtask

    task automatic runTo(input int target);
        while (t < target) begin
            applyStimulus(1);
            t++;
        end
    endtask

    initial begin
        Reset = 1'b1; Timeset = 1'b0; Alarmset = 1'b0; Minadv = 1'b0; Hrsadv = 1'b0;
        Dayadv = 1'b0; Alarmon = 1'b0; Snooze = 1'b0; AlarmDays = '0;

        $display("[TB] reset state");
        applyStimulus(2);
        t = 0;
        checkTime(0);
        checkOutput("AMinReset", 32'(AMin), 0);
        checkOutput("AHrsReset", 32'(AHrs), 0);
        checkAlarm(1'b0, 1'b0);

        $display("[TB] free run through a full week");
        Reset = 1'b0;
        for (int i = 1; i <= NS * NM * NH * ND; i++) begin
            applyStimulus(1);
            t = i;
            checkTime(t);
        end

        $display("[TB] manual time setting");
        applyStimulus(2);
        t = 50;
        checkTime(t);
        Timeset = 1'b1; Minadv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            checkOutput("setMin", 32'(TMin), (i + 1) % NM);
            checkOutput("setSecFrozen", 32'(TSec), 2);
            checkOutput("setHrsHold", 32'(THrs), 0);
        end
        Minadv = 1'b0; Hrsadv = 1'b1;
        applyStimulus(1);
        checkOutput("setHrs", 32'(THrs), 1);
        checkOutput("setHrsMinHold", 32'(TMin), 1);
        Hrsadv = 1'b0; Dayadv = 1'b1;
        applyStimulus(1);
        checkOutput("setDay", 32'(TDay), 1);
        checkOutput("setDayHrsHold", 32'(THrs), 1);
        Dayadv = 1'b0; Alarmset = 1'b1; Minadv = 1'b1;
        applyStimulus(1);
        checkOutput("bothModesTMin", 32'(TMin), 2);
        checkOutput("bothModesAMinHold", 32'(AMin), 0);
        Timeset = 1'b0; Alarmset = 1'b0; Minadv = 1'b0;

        $display("[TB] alarm setting");
        Reset = 1'b1;
        applyStimulus(1);
        Reset = 1'b0;
        t = 0;
        checkTime(0);
        Alarmset = 1'b1; Hrsadv = 1'b1;
        applyStimulus(1);
        t = 1;
        checkOutput("AHrsSet", 32'(AHrs), 1);
        checkOutput("AHrsSetSecRuns", 32'(TSec), 1);
        Hrsadv = 1'b0; Minadv = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1);
            t++;
            checkOutput("AMinWrap", 32'(AMin), i % NM);
        end
        Alarmset = 1'b0; Minadv = 1'b0;
        checkOutput("AHrsHeld", 32'(AHrs), 1);

        $display("[TB] ring on day 0, silent on day 1");
        Alarmon = 1'b1; AlarmDays = 2'b01;
        runTo(12);
        checkTime(12);
        checkAlarm(1'b0, 1'b0);
        for (int i = 0; i < RING_SEC; i++) begin
            applyStimulus(1);
            t++;
            checkAlarm(1'b1, 1'b0);
        end
        applyStimulus(1);
        t++;
        checkAlarm(1'b0, 1'b0);
        runTo(36);
        checkTime(36);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            t++;
            checkAlarm(1'b0, 1'b0);
        end

        $display("[TB] snooze");
        runTo(60);
        applyStimulus(1);
        t++;
        checkAlarm(1'b1, 1'b0);
        Snooze = 1'b1;
        applyStimulus(1);
        t++;
        checkAlarm(1'b0, 1'b1);
        Snooze = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            t++;
            checkAlarm(1'b0, 1'b1);
        end
        for (int i = 0; i < RING_SEC; i++) begin
            applyStimulus(1);
            t++;
            checkAlarm(1'b1, 1'b0);
        end
        applyStimulus(1);
        t++;
        checkAlarm(1'b0, 1'b0);

        $display("[TB] disarm beats snooze");
        runTo(108);
        applyStimulus(1);
        t++;
        checkAlarm(1'b1, 1'b0);
        Snooze = 1'b1; Alarmon = 1'b0;
        applyStimulus(1);
        t++;
        checkAlarm(1'b0, 1'b0);
        Snooze = 1'b0; Alarmon = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1);
            t++;
            checkAlarm(1'b0, 1'b0);
        end

        $display("[TB] reset during snooze");
        runTo(156);
        applyStimulus(1);
        t++;
        checkAlarm(1'b1, 1'b0);
        Snooze = 1'b1;
        applyStimulus(1);
        t++;
        checkAlarm(1'b0, 1'b1);
        Snooze = 1'b0;
        applyStimulus(1);
        t++;
        checkAlarm(1'b0, 1'b1);
        Reset = 1'b1; AlarmDays = 2'b10;
        applyStimulus(1);
        t = 0;
        checkTime(0);
        checkOutput("AMinMidReset", 32'(AMin), 0);
        checkOutput("AHrsMidReset", 32'(AHrs), 0);
        checkAlarm(1'b0, 1'b0);
        Reset = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            applyStimulus(1);
            t = i;
            checkAlarm(1'b0, 1'b0);
        end
        applyStimulus(1);
        t++;
        checkTime(t);
        checkAlarm(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
